// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared definitions for the RTC physical bus stage.
//
// Purpose:
//   State encodings, bus idle constants and default timing values.
//   The upstream RTC read/write FSMs reuse the timing defaults.
//   phase_load() maps a state to the value the phase timer must be
//   loaded with when that state is entered.
//
// Contents:
//   state_t            4-bit bus-cycle state encoding
//   BUS_IDLE_STROBES   {cs, rd, wr} with every strobe released
//   STROBES_WR         {cs, rd, wr} for a write strobe
//   STROBES_RD         {cs, rd, wr} for a read strobe
//   DEF_T_*            default timing values in clock cycles
//   phase_load()       returns (phase length - 1) for a state
package rtc_bus_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_ADDR_SETUP  = 4'd1,
    ST_ADDR_STROBE = 4'd2,
    ST_ADDR_HOLD   = 4'd3,
    ST_GAP         = 4'd4,
    ST_DATA_SETUP  = 4'd5,
    ST_DATA_STROBE = 4'd6,
    ST_DATA_HOLD   = 4'd7,
    ST_DONE        = 4'd8
  } state_t;

  // Strobe vectors are ordered {cs, rd, wr}. All of them are active-low.
  localparam logic [2:0] BUS_IDLE_STROBES = 3'b111;
  localparam logic [2:0] STROBES_WR       = 3'b010;
  localparam logic [2:0] STROBES_RD       = 3'b001;

  localparam int DEF_T_SETUP  = 4;
  localparam int DEF_T_STROBE = 8;
  localparam int DEF_T_HOLD   = 4;
  localparam int DEF_T_GAP    = 4;

  // The timer counts down to zero and then the state advances.
  // A phase of N cycles therefore loads N-1.
  // IDLE and DONE do not use the count, so they load 0.
  function automatic logic [7:0] phase_load(
    input state_t s,
    input int     t_setup,
    input int     t_strobe,
    input int     t_hold,
    input int     t_gap
  );
    int len;
    len = 1;
    case (s)
      ST_ADDR_SETUP, ST_DATA_SETUP:   len = t_setup;
      ST_ADDR_STROBE, ST_DATA_STROBE: len = t_strobe;
      ST_ADDR_HOLD, ST_DATA_HOLD:     len = t_hold;
      ST_GAP:                         len = t_gap;
      default:                        len = 1;
    endcase
    return 8'(len - 1);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter used to time every bus phase.
//
// Purpose:
//   A single instance is shared by all bus states. It is loaded on
//   state entry and reports zero when the phase has run its length.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   load      in   load load_val on the next edge
//   load_val  in   8-bit value to load
//   zero      out  count has reached 0
module rtc_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] count;

  // The count saturates at zero.
  // The controller always reloads it on the next state entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed address/data bus controller.
//
// Purpose:
//   Takes one transaction request from the RTC read/write FSMs. It then
//   runs a complete address phase followed by a data phase on the
//   multiplexed RTC bus, and enforces setup, strobe, hold and
//   turnaround timing.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   start     in   request pulse, sampled only in IDLE
//   is_write  in   1 = write, 0 = read (latched on accept)
//   addr      in   RTC register address (latched on accept)
//   wdata     in   write data (latched on accept)
//   ad_in     in   AD pad input, sampled at the end of a read strobe
//   ad_out    out  AD pad output value
//   ad_oe     out  AD pad output enable
//   a_d       out  0 = address phase, 1 = data phase
//   cs        out  chip select, active-low
//   rd        out  read strobe, active-low
//   wr        out  write strobe, active-low
//   rdata     out  last captured read data
//   busy      out  high from the accepted start through DONE
//   done      out  one-cycle completion pulse
module rtc_bus_ctrl
  import rtc_bus_ctrl_pkg::*;
#(
  parameter int T_SETUP  = DEF_T_SETUP,
  parameter int T_STROBE = DEF_T_STROBE,
  parameter int T_HOLD   = DEF_T_HOLD,
  parameter int T_GAP    = DEF_T_GAP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       is_write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  state_t     state;
  state_t     state_next;

  logic       lat_write;
  logic       lat_write_next;
  logic [7:0] lat_addr;
  logic [7:0] lat_addr_next;
  logic [7:0] lat_wdata;
  logic [7:0] lat_wdata_next;

  logic       accept;
  logic       capture;

  logic       tmr_load;
  logic [7:0] tmr_load_val;
  logic       tmr_zero;

  logic       a_d_next;
  logic       ad_oe_next;
  logic [7:0] ad_out_next;
  logic [2:0] strobes_next;

  rtc_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  assign accept = (state == ST_IDLE) && start;

  // The request fields are captured only on an accepted start.
  // The upstream FSM may change its inputs freely mid-transaction.
  always_comb begin
    lat_write_next = lat_write;
    lat_addr_next  = lat_addr;
    lat_wdata_next = lat_wdata;
    if (accept) begin
      lat_write_next = is_write;
      lat_addr_next  = addr;
      lat_wdata_next = wdata;
    end
  end

  // The phase sequence advances when the shared timer reaches zero.
  // Every transition reloads the timer with the next phase length.
  // DONE always lasts exactly one cycle, and start is not looked at
  // there. This guarantees at least one IDLE cycle between transactions.
  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = 8'd0;
    case (state)
      ST_IDLE:        if (start)    state_next = ST_ADDR_SETUP;
      ST_ADDR_SETUP:  if (tmr_zero) state_next = ST_ADDR_STROBE;
      ST_ADDR_STROBE: if (tmr_zero) state_next = ST_ADDR_HOLD;
      ST_ADDR_HOLD:   if (tmr_zero) state_next = ST_GAP;
      ST_GAP:         if (tmr_zero) state_next = ST_DATA_SETUP;
      ST_DATA_SETUP:  if (tmr_zero) state_next = ST_DATA_STROBE;
      ST_DATA_STROBE: begin
        if (tmr_zero) begin
          state_next = ST_DATA_HOLD;
          capture    = !lat_write;
        end
      end
      ST_DATA_HOLD:   if (tmr_zero) state_next = ST_DONE;
      ST_DONE:        state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
    if (state_next != state) begin
      tmr_load     = 1'b1;
      tmr_load_val = phase_load(state_next, T_SETUP, T_STROBE, T_HOLD, T_GAP);
    end
  end

  // Pad values are decoded from the state being entered.
  // They are registered on the same edge as the state, so the pads
  // change exactly at phase boundaries and never glitch.
  // The address is always transferred with a wr strobe.
  // A read only releases the bus during the data phase.
  always_comb begin
    a_d_next     = 1'b1;
    ad_oe_next   = 1'b0;
    ad_out_next  = 8'd0;
    strobes_next = BUS_IDLE_STROBES;
    case (state_next)
      ST_ADDR_SETUP, ST_ADDR_HOLD: begin
        a_d_next    = 1'b0;
        ad_oe_next  = 1'b1;
        ad_out_next = lat_addr_next;
      end
      ST_ADDR_STROBE: begin
        a_d_next     = 1'b0;
        ad_oe_next   = 1'b1;
        ad_out_next  = lat_addr_next;
        strobes_next = STROBES_WR;
      end
      ST_DATA_SETUP, ST_DATA_HOLD: begin
        if (lat_write_next) begin
          ad_oe_next  = 1'b1;
          ad_out_next = lat_wdata_next;
        end
      end
      ST_DATA_STROBE: begin
        if (lat_write_next) begin
          ad_oe_next   = 1'b1;
          ad_out_next  = lat_wdata_next;
          strobes_next = STROBES_WR;
        end else begin
          strobes_next = STROBES_RD;
        end
      end
      default: begin
        a_d_next     = 1'b1;
        ad_oe_next   = 1'b0;
        ad_out_next  = 8'd0;
        strobes_next = BUS_IDLE_STROBES;
      end
    endcase
  end

  // State, request latches and all pad outputs share one register stage.
  // Reset forces the bus idle immediately, clears rdata and
  // suppresses any pending done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      lat_write    <= 1'b0;
      lat_addr     <= 8'd0;
      lat_wdata    <= 8'd0;
      a_d          <= 1'b1;
      ad_oe        <= 1'b0;
      ad_out       <= 8'd0;
      {cs, rd, wr} <= BUS_IDLE_STROBES;
      rdata        <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      lat_write    <= lat_write_next;
      lat_addr     <= lat_addr_next;
      lat_wdata    <= lat_wdata_next;
      a_d          <= a_d_next;
      ad_oe        <= ad_oe_next;
      ad_out       <= ad_out_next;
      {cs, rd, wr} <= strobes_next;
      busy         <= (state_next != ST_IDLE);
      done         <= (state_next == ST_DONE);
      if (capture) begin
        rdata <= ad_in;
      end
    end
  end

endmodule
